// File: rtl/earth_cameraout_if.sv
// earth_cameraout_if: Ethernet RX FIFO, camera FIFO and status signals of the bridge.
// EARTH_CAMOUT_SEQCHK_EN adds the line_num status output.
interface earth_cameraout_if;
    logic        en;
    logic [63:0] erx_dout;
    logic        erx_empty;
    logic        erx_rden;
    logic        rx_pkt_done;
    logic [15:0] rx_data_length;
    logic [63:0] cam_din;
    logic        cam_wren;
    logic        cam_full;
    logic        linedone;
    logic [15:0] line_total_data;
    logic        line_err;
    logic [15:0] rx_err_cnt;
`ifdef EARTH_CAMOUT_SEQCHK_EN
    logic [15:0] line_num;
    modport master (input en, erx_dout, erx_empty, rx_pkt_done, rx_data_length, cam_full,
                    output erx_rden, cam_din, cam_wren, linedone, line_total_data, line_err, rx_err_cnt, line_num);
    modport slave (output en, erx_dout, erx_empty, rx_pkt_done, rx_data_length, cam_full,
                   input erx_rden, cam_din, cam_wren, linedone, line_total_data, line_err, rx_err_cnt, line_num);
`else
    modport master (input en, erx_dout, erx_empty, rx_pkt_done, rx_data_length, cam_full,
                    output erx_rden, cam_din, cam_wren, linedone, line_total_data, line_err, rx_err_cnt);
    modport slave (output en, erx_dout, erx_empty, rx_pkt_done, rx_data_length, cam_full,
                   input erx_rden, cam_din, cam_wren, linedone, line_total_data, line_err, rx_err_cnt);
`endif
endinterface

// File: rtl/earth_cameraout.sv
// earth_cameraout: moves one UDP payload per line from the Ethernet RX FIFO into the camera FIFO.
// EARTH_CAMOUT_SEQCHK_EN strips and sequence-checks a leading line-number header word.
module earth_cameraout #(
    parameter int MAX_WORDS = 1024
) (
    input logic clk,
    input logic rst,
    earth_cameraout_if.master bus
);
    typedef enum logic [1:0] {IDLE, XFER, DONE, DRAIN} state_t;
    localparam logic [13:0] MAXW = 14'(MAX_WORDS);
    state_t state, nxt;
    logic [1:0] sr;
    logic [15:0] payload, len_p, err_cnt, total;
    logic [13:0] words, len_w, rd_cnt;
    logic run, start, short_len, more, trunc, rden, wr_q, err, hdr, mism;

    assign run = bus.en && !rst;
    assign start = run && state == IDLE && sr == 2'b01;
    assign short_len = bus.rx_data_length < 16'd9;
    assign len_p = bus.rx_data_length - 16'd8;
    assign len_w = {1'b0, len_p[15:3]} + {13'd0, |len_p[2:0]};
    assign more = rd_cnt < words;
    assign trunc = bus.erx_empty && more && !bus.rx_pkt_done;

`ifdef EARTH_CAMOUT_SEQCHK_EN
    logic [15:0] exp_num, hdr_num, line_num;
    logic hdr_q;
    assign hdr = rd_cnt == 14'd0;
    assign mism = hdr_num != exp_num;
    assign bus.line_num = line_num;
    always_ff @(posedge clk) begin
        if (!run) begin
            exp_num <= '0;
            hdr_num <= '0;
            line_num <= '0;
            hdr_q <= 1'b0;
        end else begin
            hdr_q <= rden && state == XFER && hdr;
            if (hdr_q) hdr_num <= bus.erx_dout[15:0];
            if (state == DONE) begin
                exp_num <= hdr_num + 16'd1;
                line_num <= hdr_num;
            end
        end
    end
`else
    assign hdr = 1'b0;
    assign mism = 1'b0;
`endif

    always_comb begin
        nxt = state;
        rden = 1'b0;
        err = 1'b0;
        if (!run) nxt = IDLE;
        else case (state)
            IDLE: if (start) begin
                err = short_len;
                nxt = short_len ? IDLE : (len_w > MAXW ? DRAIN : XFER);
            end
            XFER: begin
                rden = !bus.erx_empty && !bus.cam_full && more;
                err = more && trunc;
                nxt = !more ? DONE : (trunc ? IDLE : XFER);
            end
            DONE: begin
                err = mism;
                nxt = IDLE;
            end
            default: begin
                rden = !bus.erx_empty && more;
                err = !more || trunc;
                nxt = err ? IDLE : DRAIN;
            end
        endcase
    end

    // Writes echo XFER reads one cycle later, when the RX FIFO data is valid.
    always_ff @(posedge clk) begin
        state <= nxt;
        sr <= run ? {sr[0], bus.rx_pkt_done} : 2'b00;
        rd_cnt <= (!run || state == IDLE) ? '0 : rd_cnt + 14'(rden);
        wr_q <= rden && state == XFER && !hdr;
        if (!run) begin
            payload <= '0;
            words <= '0;
            total <= '0;
        end else begin
            if (start) begin
                payload <= len_p;
                words <= len_w;
            end
            if (state == DONE) total <= payload;
        end
        if (rst) err_cnt <= '0;
        else if (err && state != IDLE && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end

    assign bus.erx_rden = rden;
    assign bus.cam_wren = wr_q;
    assign bus.cam_din = wr_q ? bus.erx_dout : '0;
    assign bus.linedone = run && state == DONE;
    assign bus.line_err = err;
    assign bus.line_total_data = total;
    assign bus.rx_err_cnt = err_cnt;
endmodule

// File: tb/tb_earth_cameraout.sv
// tb_earth_cameraout: directed lines through a modelled RX FIFO; a monitor scores every
// camera write and linedone against queues filled when the stimulus is issued.
module tb_earth_cameraout;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    earth_cameraout_if bus();
    earth_cameraout #(.MAX_WORDS(1024)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0, errors = 0;
    int rd_seen = 0, wr_seen = 0, lines_seen = 0, err_seen = 0;
    logic [63:0] erx_q[$], exp_q[$];
    logic [15:0] len_q[$];
    logic [63:0] nxt_dout = '0;
    logic have = 1'b0, empty_nxt = 1'b1, bp_en = 1'b0, len_pend = 1'b0;
    logic [15:0] len_exp = '0;
    int ph = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // RX FIFO model: data and empty flag change after the clock edge.
    always @(posedge clk) begin
        if (have) bus.erx_dout <= nxt_dout;
        bus.erx_empty <= empty_nxt;
    end

    always @(negedge clk) begin
        if (!bp_en) bus.cam_full = 1'b0;
        else if (++ph == 3) begin
            ph = 0;
            bus.cam_full = !bus.cam_full;
        end
    end

    always @(negedge clk) begin
        #2;
        if (len_pend) begin
            chk("line_total_data", 64'(bus.line_total_data), 64'(len_exp));
            len_pend = 1'b0;
        end
        if (bus.cam_wren) begin
            wr_seen++;
            if (exp_q.size() == 0) chk("unexpected_write", 64'(bus.cam_din), 64'hDEAD_0000_0000_DEAD ^ bus.cam_din ^ 64'h1);
            else chk("cam_din", bus.cam_din, exp_q.pop_front());
        end
        if (bus.cam_full) chk("rden_while_full", 64'(bus.erx_rden), 64'd0);
        if (bus.linedone) begin
            lines_seen++;
            chk("words_left_at_linedone", 64'(exp_q.size()), 64'd0);
            if (len_q.size() == 0) chk("unexpected_linedone", 64'd1, 64'd0);
            else begin
                len_exp = len_q.pop_front();
                len_pend = 1'b1;
            end
        end
        if (bus.line_err) err_seen++;
        have = bus.erx_rden;
        if (have) begin
            rd_seen++;
            nxt_dout = erx_q.pop_front();
        end
        empty_nxt = erx_q.size() == 0;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_line(input int n, input logic good, input int base);
        logic [63:0] w;
        for (int i = 0; i < n; i++) begin
            w = {16'hCAFE, 16'(base), 32'(i * 7 + 1)};
            erx_q.push_back(w);
            if (good) exp_q.push_back(w);
        end
    endtask

    task automatic pulse(input logic [15:0] len);
        bus.rx_data_length = len;
        bus.rx_pkt_done = 1'b1;
        cyc(1);
        bus.rx_pkt_done = 1'b0;
    endtask

    task automatic settle(input int budget, input string name);
        int n = 0;
        while (erx_q.size() != 0 && n < budget) begin
            cyc(1);
            n++;
        end
        if (n >= budget) chk({name, "_timeout"}, 64'(erx_q.size()), 64'd0);
        cyc(8);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r0, w0, n;
        bus.en = 1'b1;
        bus.rx_pkt_done = 1'b0;
        bus.rx_data_length = '0;
        bus.erx_dout = '0;
        bus.erx_empty = 1'b1;
        cyc(3);
        chk("rst_rden", 64'(bus.erx_rden), 0);
        chk("rst_wren", 64'(bus.cam_wren), 0);
        chk("rst_linedone", 64'(bus.linedone), 0);
        chk("rst_line_err", 64'(bus.line_err), 0);
        chk("rst_cam_din", bus.cam_din, 0);
        chk("rst_total", 64'(bus.line_total_data), 0);
        chk("rst_err_cnt", 64'(bus.rx_err_cnt), 0);
        rst = 1'b0;
        cyc(2);

        push_line(128, 1'b1, 1); len_q.push_back(16'd1024);
        pulse(16'd1032); settle(2000, "good");
        chk("good_lines", 64'(lines_seen), 1);
        chk("good_total", 64'(bus.line_total_data), 1024);

        push_line(2, 1'b1, 2); len_q.push_back(16'd13);
        pulse(16'd21); settle(200, "odd");
        chk("odd_lines", 64'(lines_seen), 2);
        chk("odd_total", 64'(bus.line_total_data), 13);

        bp_en = 1'b1;
        push_line(64, 1'b1, 3); len_q.push_back(16'd512);
        pulse(16'd520); settle(2000, "bp");
        bp_en = 1'b0;
        chk("bp_lines", 64'(lines_seen), 3);
        chk("bp_total", 64'(bus.line_total_data), 512);

        push_line(40, 1'b1, 4);
        pulse(16'd520); settle(2000, "trunc");
        chk("trunc_line_err", 64'(err_seen), 1);
        chk("trunc_err_cnt", 64'(bus.rx_err_cnt), 1);
        chk("trunc_no_linedone", 64'(lines_seen), 3);
        push_line(16, 1'b1, 5); len_q.push_back(16'd128);
        pulse(16'd136); settle(500, "after_trunc");
        chk("after_trunc_lines", 64'(lines_seen), 4);
        chk("after_trunc_total", 64'(bus.line_total_data), 128);

        r0 = rd_seen;
        pulse(16'd8); cyc(10);
        chk("short_line_err", 64'(err_seen), 2);
        chk("short_no_reads", 64'(rd_seen - r0), 0);
        chk("short_lines", 64'(lines_seen), 4);

        w0 = wr_seen; r0 = rd_seen;
        push_line(1025, 1'b0, 6);
        pulse(16'd8208); settle(5000, "oversize");
        chk("over_line_err", 64'(err_seen), 3);
        chk("over_err_cnt", 64'(bus.rx_err_cnt), 2);
        chk("over_drained", 64'(rd_seen - r0), 1025);
        chk("over_no_writes", 64'(wr_seen - w0), 0);

        push_line(1024, 1'b1, 7); len_q.push_back(16'd8192);
        pulse(16'd8200); settle(5000, "max");
        chk("max_lines", 64'(lines_seen), 5);
        chk("max_total", 64'(bus.line_total_data), 8192);

        w0 = wr_seen; n = 0;
        push_line(100, 1'b1, 8);
        pulse(16'd808);
        while (wr_seen - w0 < 10 && n < 200) begin
            cyc(1);
            n++;
        end
        chk("reset_wait", 64'(n < 200), 1);
        rst = 1'b1;
        cyc(1);
        chk("midrst_rden", 64'(bus.erx_rden), 0);
        chk("midrst_wren", 64'(bus.cam_wren), 0);
        chk("midrst_linedone", 64'(bus.linedone), 0);
        chk("midrst_line_err", 64'(bus.line_err), 0);
        chk("midrst_cam_din", bus.cam_din, 0);
        chk("midrst_total", 64'(bus.line_total_data), 0);
        chk("midrst_err_cnt", 64'(bus.rx_err_cnt), 0);
        rst = 1'b0;
        cyc(2);
        erx_q.delete();
        exp_q.delete();
        cyc(2);
        push_line(20, 1'b1, 9); len_q.push_back(16'd160);
        pulse(16'd168); settle(500, "after_rst");
        chk("after_rst_lines", 64'(lines_seen), 6);
        chk("after_rst_total", 64'(bus.line_total_data), 160);
        chk("after_rst_err_cnt", 64'(bus.rx_err_cnt), 0);
        chk("final_err_pulses", 64'(err_seen), 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
